// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and helpers for the fetch front end.
//            NOP_INSTR is the bubble presented to decode when the queue is
//            empty. OPCODE_MSB/LSB locate the opcode field in an instruction.
//            occ_width() gives the width of an occupancy count for a given
//            queue depth, wide enough to hold the value DEPTH itself.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 27;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH x WIDTH synchronous FIFO with a single-cycle flush.
//            A push and a pop in the same cycle are both honoured, even when
//            the FIFO is full. Flush empties the FIFO and overrides any push
//            or pop presented in the same cycle.
// Ports    : clk_i    - clock, rising edge
//            rst_ni   - asynchronous active-low reset
//            flush_i  - discard all entries this cycle
//            push_i   - write data_i at the tail
//            data_i   - write data
//            pop_i    - remove the head entry (ignored when empty)
//            data_o   - head entry (undefined content when empty)
//            full_o   - DEPTH entries held
//            empty_o  - no entries held
//            count_o  - entries held
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i & ~flush_i;
  assign w_pop  = pop_i & ~flush_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + AW'(1);
      if (w_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Purpose  : Fetch front end. Owns the PC, issues word reads to a 1-cycle
//            synchronous imem and buffers the returned instructions in a
//            DEPTH-entry queue that feeds decode over valid/ready. A decode
//            stall does not freeze the PC. A redirect flushes the queue and
//            drops the read in flight.
// Ports    : clock, reset_n           - clock / async active-low reset
//            imem_req, imem_addr      - read strobe and word address
//            imem_data                - data for last cycle's request
//            redirect_valid/_pc       - execute-stage redirect
//            dec_valid/ready/instr    - decode handshake, NOP when empty
//            dec_pc_next              - head PC + 1
//            occupancy                - entries in the queue
//            perf_fetched/_flushed    - event counters (FETCH_PERF_EN only)
// Macros   : FETCH_PERF_EN adds the two performance counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          INSTR_W  = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_W-1:0]     dec_instr,
  output logic [31:0]            dec_pc_next,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`endif
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [31:0]          pc_q, pc_d;
  logic                 inflight_q, inflight_d;
  logic [31:0]          pcn_q, pcn_d;      // PC+1 of the read in flight
  logic                 run_q;             // low for the first cycle after reset release
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [OCC_W:0]       w_pending;
  logic [INSTR_W+31:0]  w_head;

  // Entries that will be held once the in-flight read lands, net of this
  // cycle's pop. Issuing only while this is below DEPTH guarantees the
  // response always finds room.
  assign w_pop     = dec_valid & dec_ready;
  assign w_pending = {1'b0, occupancy} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(w_pop);
  assign imem_req  = run_q & ~redirect_valid & (w_pending < (OCC_W+1)'(DEPTH));
  assign imem_addr = pc_q[ADDR_W-1:0];

  // A redirect discards the response arriving this cycle along with the queue.
  assign w_push = inflight_q & ~redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    pcn_d      = pcn_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d  = pc_q + 32'd1;
      pcn_d = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      pcn_q      <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pcn_q      <= pcn_d;
      inflight_q <= inflight_d;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + 32)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .flush_i (redirect_valid),
    .push_i  (w_push),
    .data_i  ({pcn_q, imem_data}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (occupancy)
  );

  assign dec_valid   = ~w_empty;
  assign dec_instr   = w_empty ? INSTR_W'(NOP_INSTR) : w_head[INSTR_W-1:0];
  assign dec_pc_next = w_empty ? 32'h0 : w_head[INSTR_W+31:INSTR_W];

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push && w_full && !w_pop));

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (w_push) fetched_q <= fetched_q + 32'd1;
      if (redirect_valid) flushed_q <= flushed_q + 32'(occupancy) + 32'(inflight_q);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Purpose  : Directed self-checking bench for fetch_queue_unit with default
//            parameters (DEPTH=4, RESET_PC=0). The imem model returns
//            address + 100 one cycle after each request.
// Macros   : FETCH_PERF_EN also checks the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

  logic        clock;
  logic        reset_n;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc_next;
  logic [2:0]  occupancy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc_next    (dec_pc_next),
    .occupancy      (occupancy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous imem: data for a request appears one cycle later.
  always @(posedge clock)
    imem_data <= imem_req ? (32'(imem_addr) + 32'd100) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge that starts cycle c0,
  // the first cycle in which the DUT may request.
  task automatic do_reset();
    reset_n        = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    imem_data = 32'h0;
    // ---------------- reset state ----------------
    reset_n        = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) tick();
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_instr", dec_instr,      32'h0);
    check("rst_occ",   32'(occupancy), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_req",   32'(imem_req),  32'd0);
    tick();

    // ---------------- streaming, dec_ready=1 ----------------
    dec_ready = 1'b1;
    #1;
    check("s_req_c0",  32'(imem_req),  32'd1);
    check("s_addr_c0", 32'(imem_addr), 32'd0);
    tick();
    check("s_empty_c1", 32'(dec_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s_valid_%0d", k), 32'(dec_valid), 32'd1);
      check($sformatf("s_instr_%0d", k), dec_instr,      32'(100 + k));
      check($sformatf("s_pcn_%0d", k),   dec_pc_next,    32'(1 + k));
      tick();
    end

    // ---------------- stall, saturate, single pop ----------------
    do_reset();
    repeat (10) tick();
    check("st_occ",   32'(occupancy), 32'd4);
    check("st_req",   32'(imem_req),  32'd0);
    check("st_addr",  32'(imem_addr), 32'd4);
    check("st_instr", dec_instr,      32'd100);
    dec_ready = 1'b1;
    #1;
    check("pulse_req",  32'(imem_req),  32'd1);
    check("pulse_addr", 32'(imem_addr), 32'd4);
    tick();
    dec_ready = 1'b0;
    #1;
    check("pulse_occ3",  32'(occupancy), 32'd3);
    check("pulse_instr", dec_instr,      32'd101);
    check("pulse_noreq", 32'(imem_req),  32'd0);
    tick();
    check("pulse_occ4",  32'(occupancy), 32'd4);
    dec_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("drain_instr_%0d", k), dec_instr, 32'(101 + k));
      tick();
    end

    // ---------------- redirect with 3 queued + 1 inflight ----------------
    do_reset();
    repeat (4) tick();
    check("rd_occ_pre", 32'(occupancy), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check("rd_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    #1;
    check("rd_occ",   32'(occupancy), 32'd0);
    check("rd_valid", 32'(dec_valid), 32'd0);
    check("rd_instr", dec_instr,      32'h0);
    check("rd_req2",  32'(imem_req),  32'd1);
    check("rd_addr",  32'(imem_addr), 32'h40);
`ifdef FETCH_PERF_EN
    check("rd_perf_fetched", perf_fetched, 32'd3);
    check("rd_perf_flushed", perf_flushed, 32'd4);
`endif
    tick();
    check("rd_valid_c6", 32'(dec_valid), 32'd0);
    tick();
    check("rd_instr_c7", dec_instr,   32'h40 + 32'd100);
    check("rd_pcn_c7",   dec_pc_next, 32'h41);

    // ---------------- redirect + pop, then back-to-back ----------------
    do_reset();
    dec_ready = 1'b1;
    repeat (3) tick();
    check("rp_instr_pre", dec_instr, 32'd101);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_pc = 32'hC0;
    #1;
    check("rp_valid", 32'(dec_valid), 32'd0);
    check("rp_occ",   32'(occupancy), 32'd0);
    check("rp_req",   32'(imem_req),  32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rp_req2",  32'(imem_req),  32'd1);
    check("rp_addr",  32'(imem_addr), 32'hC0);
    check("rp_valid2", 32'(dec_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("rp_perf_flushed", perf_flushed, 32'd2);
`endif
    tick();
    check("rp_valid3", 32'(dec_valid), 32'd0);
    tick();
    check("rp_instr", dec_instr,   32'hC0 + 32'd100);
    check("rp_pcn",   dec_pc_next, 32'hC1);

    // ---------------- reset mid-stream ----------------
    do_reset();
    dec_ready = 1'b1;
    repeat (4) tick();
    check("mr_instr_pre", dec_instr, 32'd102);
    reset_n = 1'b0;
    #1;
    check("mr_occ",   32'(occupancy), 32'd0);
    check("mr_valid", 32'(dec_valid), 32'd0);
    check("mr_instr", dec_instr,      32'h0);
    check("mr_req",   32'(imem_req),  32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    check("mr_req2", 32'(imem_req),  32'd1);
    check("mr_addr", 32'(imem_addr), 32'd0);
    tick();
    tick();
    check("mr_instr2", dec_instr,   32'd100);
    check("mr_pcn2",   dec_pc_next, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
